// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory for the IF stage: registered reads, LOAD/RUN gating,
// bubble insertion on memory conflicts, and wrap-or-fault handling of out-of-range PCs.
module instr_fetch_mem #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned IDX_W    = $clog2(DEPTH),
    parameter int unsigned PC_SHIFT = 2,
    parameter bit          WRAP_EN  = 1'b1,
    parameter logic [DATA_W-1:0] NOP_WORD = 16'h0800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch_en,
    input  logic              mem_conflict,
    input  logic              load_we,
    input  logic [IDX_W-1:0]  load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_done,
    output logic [DATA_W-1:0] instruction,
    output logic              inst_valid,
    output logic              pc_fault,
    output logic              ready
);

    // state   | meaning
    // ST_LOAD | loader owns the array; outputs forced to NOP, fetches ignored
    // ST_RUN  | fetches served from the array, one-cycle read latency
    typedef enum logic {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] instruction_q, instruction_d;
    logic              inst_valid_q, inst_valid_d;
    logic              pc_fault_q, pc_fault_d;
    logic              ready_q, ready_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] idx_full;
    logic [IDX_W-1:0]  idx;
    logic              out_of_range;
    logic [DATA_W-1:0] fetch_word;

    assign idx_full     = pc >> PC_SHIFT;
    assign idx          = idx_full[IDX_W-1:0];
    assign out_of_range = ({1'b0, idx_full} >= (ADDR_W + 1)'(DEPTH));
    // Write-first: a same-edge load to the fetched word returns the new data.
    assign fetch_word   = (load_we && (load_addr == idx)) ? load_data : mem_q[idx];

    always_comb begin
        state_d       = state_q;
        instruction_d = instruction_q;
        inst_valid_d  = inst_valid_q;
        pc_fault_d    = pc_fault_q;
        ready_d       = ready_q;
        if (state_q == ST_LOAD) begin
            instruction_d = NOP_WORD;
            inst_valid_d  = 1'b0;
            pc_fault_d    = 1'b0;
            ready_d       = load_done;
            if (load_done) begin
                state_d = ST_RUN;
            end
        end else begin
            ready_d = 1'b1;
            if (mem_conflict) begin
                instruction_d = NOP_WORD;
                inst_valid_d  = 1'b0;
                pc_fault_d    = 1'b0;
            end else if (fetch_en) begin
                if (out_of_range && !WRAP_EN) begin
                    instruction_d = NOP_WORD;
                    inst_valid_d  = 1'b0;
                    pc_fault_d    = 1'b1;
                end else begin
                    instruction_d = fetch_word;
                    inst_valid_d  = 1'b1;
                    pc_fault_d    = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_LOAD;
            instruction_q <= NOP_WORD;
            inst_valid_q  <= 1'b0;
            pc_fault_q    <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            instruction_q <= instruction_d;
            inst_valid_q  <= inst_valid_d;
            pc_fault_q    <= pc_fault_d;
            ready_q       <= ready_d;
        end
    end

    // Array is never cleared so a reset keeps the loaded program.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem_q[load_addr] <= load_data;
        end
    end

    assign instruction = instruction_q;
    assign inst_valid  = inst_valid_q;
    assign pc_fault    = pc_fault_q;
    assign ready       = ready_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: one instance per WRAP_EN setting sharing stimulus,
// checked against constant vectors and a word-array reference model.
module tb_instr_fetch_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic        fetch_en, mem_conflict, load_we, load_done;
    logic [5:0]  load_addr;
    logic [15:0] load_data;

    logic [15:0] instr0, instr1;
    logic        valid0, valid1, fault0, fault1, ready0, ready1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_mem #(.WRAP_EN(1'b0)) dut_w0 (
        .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .mem_conflict(mem_conflict),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
        .instruction(instr0), .inst_valid(valid0), .pc_fault(fault0), .ready(ready0));

    instr_fetch_mem #(.WRAP_EN(1'b1)) dut_w1 (
        .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .mem_conflict(mem_conflict),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
        .instruction(instr1), .inst_valid(valid1), .pc_fault(fault1), .ready(ready1));

    // Reference model: program words plus expected outputs for each wrap setting.
    logic [15:0] ref_mem [64];
    bit          ref_run;
    logic [15:0] exp_instr [2];
    logic        exp_valid [2];
    logic        exp_fault [2];
    logic        exp_ready;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        int unsigned word;
        if (load_we) ref_mem[load_addr] = load_data;
        if (!rst) begin
            ref_run = 0;
            for (int w = 0; w < 2; w++) begin
                exp_instr[w] = 16'h0800; exp_valid[w] = 0; exp_fault[w] = 0;
            end
            exp_ready = 0;
            return;
        end
        if (!ref_run) begin
            for (int w = 0; w < 2; w++) begin
                exp_instr[w] = 16'h0800; exp_valid[w] = 0; exp_fault[w] = 0;
            end
            if (load_done) ref_run = 1;
        end else begin
            word = 32'(pc) / 4;
            for (int w = 0; w < 2; w++) begin
                if (mem_conflict) begin
                    exp_instr[w] = 16'h0800; exp_valid[w] = 0; exp_fault[w] = 0;
                end else if (fetch_en) begin
                    if (word >= 64 && w == 0) begin
                        exp_instr[w] = 16'h0800; exp_valid[w] = 0; exp_fault[w] = 1;
                    end else begin
                        exp_instr[w] = ref_mem[word % 64]; exp_valid[w] = 1; exp_fault[w] = 0;
                    end
                end
            end
        end
        exp_ready = ref_run;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model instr w0", instr0, exp_instr[0]);
        chk("model valid w0", {15'd0, valid0}, {15'd0, exp_valid[0]});
        chk("model fault w0", {15'd0, fault0}, {15'd0, exp_fault[0]});
        chk("model instr w1", instr1, exp_instr[1]);
        chk("model valid w1", {15'd0, valid1}, {15'd0, exp_valid[1]});
        chk("model fault w1", {15'd0, fault1}, {15'd0, exp_fault[1]});
        chk("model ready w0", {15'd0, ready0}, {15'd0, exp_ready});
        chk("model ready w1", {15'd0, ready1}, {15'd0, exp_ready});
    endtask

    task automatic idle_inputs();
        fetch_en = 0; mem_conflict = 0; load_we = 0; load_done = 0;
        load_addr = '0; load_data = '0; pc = '0;
    endtask

    task automatic write_word(input logic [5:0] a, input logic [15:0] d, input logic done);
        idle_inputs();
        load_we = 1; load_addr = a; load_data = d; load_done = done;
        tick();
        idle_inputs();
    endtask

    task automatic chk_outputs(input string name, input logic [15:0] i0, input logic v0,
                               input logic f0, input logic [15:0] i1, input logic v1,
                               input logic f1, input logic rdy);
        chk({name, " instr w0"}, instr0, i0);
        chk({name, " valid w0"}, {15'd0, valid0}, {15'd0, v0});
        chk({name, " fault w0"}, {15'd0, fault0}, {15'd0, f0});
        chk({name, " instr w1"}, instr1, i1);
        chk({name, " valid w1"}, {15'd0, valid1}, {15'd0, v1});
        chk({name, " fault w1"}, {15'd0, fault1}, {15'd0, f1});
        chk({name, " ready"}, {14'd0, ready1, ready0}, {14'd0, rdy, rdy});
    endtask

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic        fe, cf, we, done;
        logic [5:0]  la;
        logic [15:0] ld;
        logic [15:0] i0; logic v0, f0;
        logic [15:0] i1; logic v1, f1;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [15:0] p, input logic fe,
                                input logic cf, input logic we, input logic [5:0] la,
                                input logic [15:0] ld, input logic done,
                                input logic [15:0] i0, input logic v0, input logic f0,
                                input logic [15:0] i1, input logic v1, input logic f1);
        vec_t v;
        v.name = n; v.pc = p; v.fe = fe; v.cf = cf; v.we = we; v.la = la; v.ld = ld;
        v.done = done; v.i0 = i0; v.v0 = v0; v.f0 = f0; v.i1 = i1; v.v1 = v1; v.f1 = f1;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        //            name          pc       fe cf we la  ld       dn  i0       v0 f0  i1       v1 f1
        tbl.push_back(mk("fetch0",  16'h0000, 1, 0, 0, 0, 16'h0,    0, 16'h4914, 1, 0, 16'h4914, 1, 0));
        tbl.push_back(mk("fetch4",  16'h0004, 1, 0, 0, 0, 16'h0,    0, 16'h0800, 1, 0, 16'h0800, 1, 0));
        tbl.push_back(mk("conflict",16'h0008, 1, 1, 0, 0, 16'h0,    0, 16'h0800, 0, 0, 16'h0800, 0, 0));
        tbl.push_back(mk("fetch8",  16'h0008, 1, 0, 0, 0, 16'h0,    0, 16'h4A01, 1, 0, 16'h4A01, 1, 0));
        tbl.push_back(mk("stall1",  16'h000C, 0, 0, 0, 0, 16'h0,    0, 16'h4A01, 1, 0, 16'h4A01, 1, 0));
        tbl.push_back(mk("stall2",  16'h000C, 0, 0, 0, 0, 16'h0,    0, 16'h4A01, 1, 0, 16'h4A01, 1, 0));
        tbl.push_back(mk("fetch12", 16'h000C, 1, 0, 0, 0, 16'h0,    0, 16'hE22F, 1, 0, 16'hE22F, 1, 0));
        tbl.push_back(mk("last",    16'h00FF, 1, 0, 0, 0, 16'h0,    0, 16'hBEEF, 1, 0, 16'hBEEF, 1, 0));
        tbl.push_back(mk("oor",     16'h0100, 1, 0, 0, 0, 16'h0,    0, 16'h0800, 0, 1, 16'h4914, 1, 0));
        tbl.push_back(mk("oorstall",16'h0100, 0, 0, 0, 0, 16'h0,    0, 16'h0800, 0, 1, 16'h4914, 1, 0));
        tbl.push_back(mk("cfstall", 16'h0100, 0, 1, 0, 0, 16'h0,    0, 16'h0800, 0, 0, 16'h0800, 0, 0));
        tbl.push_back(mk("oor2",    16'h0103, 1, 0, 0, 0, 16'h0,    0, 16'h0800, 0, 1, 16'h4914, 1, 0));
        tbl.push_back(mk("clrfault",16'h0000, 1, 0, 0, 0, 16'h0,    0, 16'h4914, 1, 0, 16'h4914, 1, 0));
        tbl.push_back(mk("bypass",  16'h0014, 1, 0, 1, 5, 16'h6D01, 0, 16'h6D01, 1, 0, 16'h6D01, 1, 0));
        tbl.push_back(mk("other",   16'h0004, 1, 0, 0, 0, 16'h0,    0, 16'h0800, 1, 0, 16'h0800, 1, 0));
        tbl.push_back(mk("refetch", 16'h0014, 1, 0, 0, 0, 16'h0,    0, 16'h6D01, 1, 0, 16'h6D01, 1, 0));
        tbl.push_back(mk("wrapbyp", 16'h0114, 1, 0, 1, 5, 16'h1234, 0, 16'h0800, 0, 1, 16'h1234, 1, 0));
        tbl.push_back(mk("doneRUN", 16'h000C, 1, 0, 0, 0, 16'h0,    1, 16'hE22F, 1, 0, 16'hE22F, 1, 0));

        idle_inputs();
        rst = 0;
        tick();
        tick();
        chk_outputs("reset", 16'h0800, 0, 0, 16'h0800, 0, 0, 0);

        rst = 1;
        pc = 16'h0000; fetch_en = 1;
        tick();
        chk_outputs("loadfetch", 16'h0800, 0, 0, 16'h0800, 0, 0, 0);

        for (int i = 0; i < 64; i++) write_word(6'(i), 16'($urandom), 0);
        write_word(6'd63, 16'hBEEF, 0);
        write_word(6'd0, 16'h4914, 0);
        write_word(6'd1, 16'h0800, 0);
        write_word(6'd2, 16'h4A01, 0);
        write_word(6'd3, 16'hE22F, 1);
        chk_outputs("enter run", 16'h0800, 0, 0, 16'h0800, 0, 0, 1);

        foreach (tbl[k]) begin
            pc = tbl[k].pc; fetch_en = tbl[k].fe; mem_conflict = tbl[k].cf;
            load_we = tbl[k].we; load_addr = tbl[k].la; load_data = tbl[k].ld;
            load_done = tbl[k].done;
            tick();
            chk_outputs(tbl[k].name, tbl[k].i0, tbl[k].v0, tbl[k].f0,
                        tbl[k].i1, tbl[k].v1, tbl[k].f1, 1);
        end
        idle_inputs();

        // Reset mid-run, then re-enter RUN without reloading.
        pc = 16'h0000; fetch_en = 1; rst = 0;
        tick();
        chk_outputs("midreset", 16'h0800, 0, 0, 16'h0800, 0, 0, 0);
        rst = 1; fetch_en = 0; load_done = 1;
        tick();
        chk_outputs("reload", 16'h0800, 0, 0, 16'h0800, 0, 0, 1);
        load_done = 0; fetch_en = 1; pc = 16'h0000;
        tick();
        chk_outputs("retained", 16'h4914, 1, 0, 16'h4914, 1, 0, 1);

        for (int c = 0; c < 400; c++) begin
            rst          = ($urandom_range(0, 59) != 0);
            pc           = 16'($urandom_range(0, 16'h013F));
            fetch_en     = ($urandom_range(0, 3) != 0);
            mem_conflict = ($urandom_range(0, 5) == 0);
            load_we      = ($urandom_range(0, 3) == 0);
            load_addr    = 6'($urandom);
            load_data    = 16'($urandom);
            load_done    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) load_addr = 6'(pc >> 2);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
